// File: rtl/arb_mux_pkg.sv
// rtl/arb_mux_pkg.sv - shared types and pointer wrap helper for arb_mux
package arb_mux_pkg;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    // Explicit wrap so non-power-of-two channel counts cycle correctly
    function automatic int next_ptr(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/arb_mux_rr_grant.sv
// rtl/arb_mux_rr_grant.sv - combinational round-robin / fixed-priority grant
module rr_grant
    import arb_mux_pkg::*;
#(
    parameter int N     = 8,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    input  arb_mode_e        mode,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    int   start;
    logic found;

    // Two passes: first from start up to N-1, then wrap from 0 to start-1
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        start = (mode == ARB_FIXED) ? 0 : int'(ptr);
        for (int k = 0; k < N; k++) begin
            if (!found && k >= start && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                idx    = SEL_W'(k);
            end
        end
        for (int k = 0; k < N; k++) begin
            if (!found && k < start && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                idx    = SEL_W'(k);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/arb_mux.sv
// rtl/arb_mux.sv - N-way arbitrating mux with one-entry registered output slice
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 8,
    parameter int MODE  = 0,
    parameter int SEL_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_sel,
    input  logic                 out_ready
);

    localparam arb_mode_e MODE_E = (MODE == 1) ? ARB_FIXED : ARB_RR;

    logic [SEL_W-1:0] ptr;
    logic [N-1:0]     gnt;
    logic [SEL_W-1:0] idx;
    logic             any;
    logic             load;
    logic [WIDTH-1:0] win_data;

    rr_grant #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_grant (
        .req  (in_valid),
        .ptr  (ptr),
        .mode (MODE_E),
        .gnt  (gnt),
        .idx  (idx),
        .any  (any)
    );

    assign load     = !out_valid || out_ready;
    assign in_ready = (rst_n && load) ? gnt : '0;

    always_comb begin
        win_data = '0;
        for (int k = 0; k < N; k++) begin
            if (gnt[k]) begin
                win_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // A held beat is dropped on reset; ptr stays 0 in fixed-priority mode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (any) begin
                out_valid <= 1'b1;
                out_data  <= win_data;
                out_sel   <= idx;
                if (MODE_E == ARB_RR) begin
                    ptr <= SEL_W'(next_ptr(int'(idx), N));
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
